atm_keypad_entry: RTL and testbench

Keypad front-end stage for the ATM controller. It collects raw key codes from the keypad scanner, assembles a one-digit account number and a four-digit PIN, and presents them as a single binary `acc_num`/`pin` pair to the ATM controller's authenticator inputs through a valid/ready handshake. It also handles backspace, cancel and inactivity timeout, so the ATM core only ever sees complete, well-formed credentials.

---
 rtl/atm_keypad_entry.sv | 205 ++++++++++++++++++++
 tb/tb_atm_keypad_entry.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM controller: assembles a 1-digit account number and a
// 4-digit PIN from raw key codes and hands them to the core over a valid/ready pair.
module atm_keypad_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  acc_num,
  output logic [13:0] pin,
  output logic [2:0]  digit_count,
  output logic [1:0]  phase,
  output logic        key_error,
  output logic        timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] K_BS     = 4'd10;
  localparam logic [3:0] K_ENTER  = 4'd11;
  localparam logic [3:0] K_CANCEL = 4'd12;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_PIN = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        acc_r, acc_nx;
  logic [3:0]        d3, d2, d1, d0;
  logic [3:0]        d3_nx, d2_nx, d1_nx, d0_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [IDLE_W-1:0] idle_r, idle_nx;
  logic [3:0]        acc_num_nx;
  logic [13:0]       pin_nx;
  logic              out_valid_nx, key_error_nx, timeout_nx;
  logic              accept, is_digit, counting;

  function automatic logic [13:0] bcd_to_bin(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c, input logic [3:0] d);
    logic [13:0] r;
    r = {10'd0, a} * 14'd1000 + {10'd0, b} * 14'd100 + {10'd0, c} * 14'd10 + {10'd0, d};
    return r;
  endfunction

  assign phase       = state;
  assign digit_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc_r     <= '0;
      d3        <= '0;
      d2        <= '0;
      d1        <= '0;
      d0        <= '0;
      cnt       <= '0;
      idle_r    <= '0;
      acc_num   <= '0;
      pin       <= '0;
      out_valid <= 1'b0;
      key_error <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      acc_r     <= acc_nx;
      d3        <= d3_nx;
      d2        <= d2_nx;
      d1        <= d1_nx;
      d0        <= d0_nx;
      cnt       <= cnt_nx;
      idle_r    <= idle_nx;
      acc_num   <= acc_num_nx;
      pin       <= pin_nx;
      out_valid <= out_valid_nx;
      key_error <= key_error_nx;
      timeout   <= timeout_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    acc_nx       = acc_r;
    d3_nx        = d3;
    d2_nx        = d2;
    d1_nx        = d1;
    d0_nx        = d0;
    cnt_nx       = cnt;
    idle_nx      = idle_r;
    acc_num_nx   = acc_num;
    pin_nx       = pin;
    out_valid_nx = out_valid;
    key_error_nx = 1'b0;
    timeout_nx   = 1'b0;
    accept       = 1'b0;
    is_digit     = (key_code <= 4'd9);
    counting     = (state == ST_PIN) || ((state == ST_ACC) && (cnt == 3'd1));

    case (state)
      ST_ACC: begin
        if (key_valid) begin
          if (is_digit && cnt == 3'd0) begin
            acc_nx = key_code;
            cnt_nx = 3'd1;
            accept = 1'b1;
          end else if (key_code == K_BS && cnt == 3'd1) begin
            cnt_nx = 3'd0;
            accept = 1'b1;
          end else if (key_code == K_ENTER && cnt == 3'd1) begin
            state_nx = ST_PIN;
            cnt_nx   = 3'd0;
            d3_nx    = '0;
            d2_nx    = '0;
            d1_nx    = '0;
            d0_nx    = '0;
            accept   = 1'b1;
          end else if (key_code == K_CANCEL) begin
            cnt_nx = 3'd0;
            accept = 1'b1;
          end
        end
      end
      ST_PIN: begin
        if (key_valid) begin
          if (is_digit && cnt < 3'd4) begin
            d3_nx  = d2;
            d2_nx  = d1;
            d1_nx  = d0;
            d0_nx  = key_code;
            cnt_nx = cnt + 3'd1;
            accept = 1'b1;
          end else if (key_code == K_BS) begin
            accept = 1'b1;
            if (cnt == 3'd0) begin
              // Backing out of an empty PIN reopens the account digit for editing.
              state_nx = ST_ACC;
              cnt_nx   = 3'd1;
            end else begin
              d0_nx  = d1;
              d1_nx  = d2;
              d2_nx  = d3;
              d3_nx  = '0;
              cnt_nx = cnt - 3'd1;
            end
          end else if (key_code == K_ENTER && cnt == 3'd4) begin
            pin_nx       = bcd_to_bin(d3, d2, d1, d0);
            acc_num_nx   = acc_r;
            out_valid_nx = 1'b1;
            state_nx     = ST_OUT;
            accept       = 1'b1;
          end else if (key_code == K_CANCEL) begin
            state_nx = ST_ACC;
            cnt_nx   = 3'd0;
            acc_nx   = '0;
            d3_nx    = '0;
            d2_nx    = '0;
            d1_nx    = '0;
            d0_nx    = '0;
            accept   = 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nx     = ST_ACC;
          out_valid_nx = 1'b0;
          cnt_nx       = 3'd0;
          acc_nx       = '0;
          d3_nx        = '0;
          d2_nx        = '0;
          d1_nx        = '0;
          d0_nx        = '0;
        end
      end
      default: state_nx = ST_ACC;
    endcase

    // A key on the would-be timeout cycle wins; the idle counter only runs mid-entry.
    if (key_valid) begin
      idle_nx      = '0;
      key_error_nx = !accept;
    end else if (counting) begin
      if (idle_r == IDLE_LAST) begin
        timeout_nx = 1'b1;
        idle_nx    = '0;
        state_nx   = ST_ACC;
        cnt_nx     = 3'd0;
        acc_nx     = '0;
        d3_nx      = '0;
        d2_nx      = '0;
        d1_nx      = '0;
        d0_nx      = '0;
      end else begin
        idle_nx = idle_r + 1'b1;
      end
    end else begin
      idle_nx = '0;
    end
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: directed scenarios plus random key traffic, checked every
// cycle against a queue-based model of the entry rules.
module tb_atm_keypad_entry;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  acc_num;
  logic [13:0] pin;
  logic [2:0]  digit_count;
  logic [1:0]  phase;
  logic        key_error;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  atm_keypad_entry #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .out_ready(out_ready), .out_valid(out_valid), .acc_num(acc_num), .pin(pin),
    .digit_count(digit_count), .phase(phase), .key_error(key_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, account digit, queue of PIN digits (newest at back)
  int m_phase = 0;
  int m_acc = 0;
  bit m_acc_set = 1'b0;
  int m_idle = 0;
  int m_q[$];
  int m_out_acc = 0;
  int m_out_pin = 0;
  bit m_ov = 1'b0;
  bit m_err = 1'b0;
  bit m_to = 1'b0;

  function automatic void m_clear();
    m_phase = 0;
    m_acc_set = 1'b0;
    m_acc = 0;
    m_q.delete();
  endfunction

  function automatic bit m_key(input int k);
    int v;
    if (k > 12) return 1'b0;
    if (m_phase == 0) begin
      if (k <= 9) begin
        if (m_acc_set) return 1'b0;
        m_acc = k;
        m_acc_set = 1'b1;
        return 1'b1;
      end
      if (k == 10) begin
        if (!m_acc_set) return 1'b0;
        m_acc_set = 1'b0;
        return 1'b1;
      end
      if (k == 11) begin
        if (!m_acc_set) return 1'b0;
        m_phase = 1;
        m_q.delete();
        return 1'b1;
      end
      m_acc_set = 1'b0;
      return 1'b1;
    end
    if (k <= 9) begin
      if (m_q.size() == 4) return 1'b0;
      m_q.push_back(k);
      return 1'b1;
    end
    if (k == 10) begin
      if (m_q.size() == 0) begin
        m_phase = 0;
        m_acc_set = 1'b1;
      end else begin
        void'(m_q.pop_back());
      end
      return 1'b1;
    end
    if (k == 11) begin
      if (m_q.size() != 4) return 1'b0;
      v = 0;
      foreach (m_q[i]) v = v * 10 + m_q[i];
      m_out_pin = v;
      m_out_acc = m_acc;
      m_phase = 2;
      m_ov = 1'b1;
      return 1'b1;
    end
    m_clear();
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_clear();
      m_idle = 0;
      m_out_acc = 0;
      m_out_pin = 0;
      m_ov = 1'b0;
      m_err = 1'b0;
      m_to = 1'b0;
    end else begin
      m_err = 1'b0;
      m_to = 1'b0;
      if (m_phase == 2) begin
        if (key_valid) m_err = 1'b1;
        if (out_ready) begin
          m_clear();
          m_ov = 1'b0;
        end
        m_idle = 0;
      end else if (key_valid) begin
        m_idle = 0;
        m_err = !m_key(int'(key_code));
      end else if (m_phase == 1 || m_acc_set) begin
        m_idle++;
        if (m_idle == TO) begin
          m_to = 1'b1;
          m_idle = 0;
          m_clear();
        end
      end else begin
        m_idle = 0;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic int m_cnt();
    if (m_phase == 0) return m_acc_set ? 1 : 0;
    return m_q.size();
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("out_valid", 32'(out_valid), 32'(m_ov));
      cmp("acc_num", 32'(acc_num), 32'(m_out_acc));
      cmp("pin", 32'(pin), 32'(m_out_pin));
      cmp("digit_count", 32'(digit_count), 32'(m_cnt()));
      cmp("phase", 32'(phase), 32'(m_phase));
      cmp("key_error", 32'(key_error), 32'(m_err));
      cmp("timeout", 32'(timeout), 32'(m_to));
    end
  end

  // All tasks start and end at a falling edge.
  task automatic press(input int k);
    key_valid = 1'b1;
    key_code = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 4'($urandom_range(0, 15));
  endtask

  task automatic press_seq(input int ks[]);
    foreach (ks[i]) press(ks[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int tcount;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    cmp("reset_out_valid", 32'(out_valid), 32'd0);
    cmp("reset_pin", 32'(pin), 32'd0);
    cmp("reset_phase", 32'(phase), 32'd0);
    rst = 1'b0;
    idle(2);

    // Basic entry, held while the core is not ready
    press_seq('{7, 11, 1, 2, 3, 4, 11});
    cmp("basic_valid", 32'(out_valid), 32'd1);
    cmp("basic_acc", 32'(acc_num), 32'd7);
    cmp("basic_pin", 32'(pin), 32'h4D2);
    idle(10);
    cmp("basic_hold_valid", 32'(out_valid), 32'd1);
    cmp("basic_hold_pin", 32'(pin), 32'd1234);
    accept_out();
    cmp("basic_xfer_valid", 32'(out_valid), 32'd0);
    cmp("basic_xfer_phase", 32'(phase), 32'd0);

    // Edit keys, then a key during OUT
    press_seq('{3, 11, 9, 8, 10, 0, 0, 5, 11});
    cmp("edit_pin", 32'(pin), 32'd9005);
    cmp("edit_acc", 32'(acc_num), 32'd3);
    press(5);
    cmp("out_key_error", 32'(key_error), 32'd1);
    cmp("out_key_pin", 32'(pin), 32'd9005);
    accept_out();

    // Backspace out of the PIN into the retained account digit
    press_seq('{3, 11, 9, 8, 10, 0, 0, 5, 10, 10, 10, 10});
    cmp("bs_pin_empty", 32'(digit_count), 32'd0);
    press(10);
    cmp("bs_phase", 32'(phase), 32'd0);
    cmp("bs_count", 32'(digit_count), 32'd1);
    press_seq('{11, 1, 2, 3, 4, 11});
    cmp("bs_acc_kept", 32'(acc_num), 32'd3);
    accept_out();

    // Rejections
    press_seq('{4, 11, 1, 2, 3});
    press(11);
    cmp("rej_enter_err", 32'(key_error), 32'd1);
    cmp("rej_enter_cnt", 32'(digit_count), 32'd3);
    idle(1);
    cmp("rej_err_pulse", 32'(key_error), 32'd0);
    press(4);
    press(5);
    cmp("rej_fifth", 32'(key_error), 32'd1);
    press(14);
    cmp("rej_illegal", 32'(key_error), 32'd1);
    press(12);
    cmp("cancel_phase", 32'(phase), 32'd0);
    cmp("cancel_cnt", 32'(digit_count), 32'd0);

    // Timeout after exactly TO idle cycles
    press_seq('{6, 11, 1, 2});
    idle(TO - 1);
    cmp("to_early", 32'(timeout), 32'd0);
    idle(1);
    cmp("to_pulse", 32'(timeout), 32'd1);
    cmp("to_phase", 32'(phase), 32'd0);
    cmp("to_cnt", 32'(digit_count), 32'd0);
    tcount = 0;
    repeat (100) begin
      @(negedge clk);
      if (timeout) tcount++;
    end
    cmp("to_idle_acc", 32'(tcount), 32'd0);

    // Key on the cycle the timeout would fire
    press_seq('{6, 11, 1, 2});
    idle(TO - 1);
    press(3);
    cmp("to_bound_none", 32'(timeout), 32'd0);
    cmp("to_bound_cnt", 32'(digit_count), 32'd3);
    cmp("to_bound_phase", 32'(phase), 32'd1);
    press(12);

    // Reset while a credential is pending
    press_seq('{8, 11, 5, 6, 7, 8, 11});
    cmp("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("rst_valid", 32'(out_valid), 32'd0);
    cmp("rst_pin", 32'(pin), 32'd0);
    cmp("rst_acc", 32'(acc_num), 32'd0);
    cmp("rst_phase", 32'(phase), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      out_ready = ($urandom_range(0, 99) < 30);
      rst = ($urandom_range(0, 499) == 0);
      if (r < 45) begin
        key_valid = 1'b1;
        key_code = 4'($urandom_range(0, 9));
      end else if (r < 70) begin
        key_valid = 1'b1;
        key_code = 4'($urandom_range(10, 15));
      end else begin
        key_valid = 1'b0;
        key_code = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        key_valid = 1'b0;
        rst = 1'b0;
        idle($urandom_range(TO - 1, TO + 3));
      end
    end
    key_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
